// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: one outstanding req/ack fetch to instruction memory,
// a single-entry output register to decode, and redirects that kill stale fetches.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [31:0] pc,
  output logic        misalign,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_e;

  // Valid/ready: imem_req/imem_addr hold until imem_ack completes the request;
  // decode takes the instruction on a cycle where if_valid & if_ready.

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        misalign_q, misalign_d;
  logic        kill_q, kill_d;
  logic [31:0] target;

  assign target = {redirect_target[31:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    kill_d      = kill_q;
    misalign_d  = redirect_valid & (redirect_target[1:0] != 2'b00);

    case (state_q)
      IDLE: begin
        state_d     = FETCH;
        imem_req_d  = 1'b1;
        pc_d        = redirect_valid ? target : pc_q;
        imem_addr_d = redirect_valid ? target : pc_q;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // Completed data is stale; start the redirected fetch back-to-back.
            pc_d        = target;
            imem_addr_d = target;
            kill_d      = 1'b0;
          end else if (kill_q) begin
            kill_d      = 1'b0;
            imem_addr_d = pc_q;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = imem_addr_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            imem_req_d = 1'b0;
            state_d    = STALL;
          end
        end else if (redirect_valid) begin
          // Request in flight must stay stable; mark its data for discard.
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      STALL: begin
        if (redirect_valid) begin
          if_valid_d  = 1'b0;
          pc_d        = target;
          imem_req_d  = 1'b1;
          imem_addr_d = target;
          state_d     = FETCH;
        end else if (if_ready) begin
          if_valid_d  = 1'b0;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
          state_d     = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 32'h0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= 32'h0;
      if_instr_q  <= 32'h0;
      misalign_q  <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      misalign_q  <= misalign_d;
      kill_q      <= kill_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign pc        = pc_q;
  assign misalign  = misalign_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed cycle table for fetch_sequencer plus hand sequences for reset
// mid-request and a misaligned redirect out of IDLE.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [31:0] pc;
  logic        misalign;
  logic [1:0]  state_dbg;

  int n_total = 0;
  int n_pass  = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .pc(pc), .misalign(misalign),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs applied during a cycle, and outputs expected during that same cycle.
  typedef struct {
    logic        rv;
    logic [31:0] rt;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rv, input logic [31:0] rt, input logic ack,
                              input logic [31:0] rdata, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_val, input logic [31:0] e_ipc,
                              input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic e_mis);
    vec_t v;
    v.rv = rv; v.rt = rt; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_ipc = e_ipc;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_mis = e_mis;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, " imem_req"},  {31'h0, imem_req}, {31'h0, v.e_req});
    chk({tag, " imem_addr"}, imem_addr,         v.e_addr);
    chk({tag, " if_valid"},  {31'h0, if_valid}, {31'h0, v.e_val});
    chk({tag, " if_pc"},     if_pc,             v.e_ipc);
    chk({tag, " if_instr"},  if_instr,          v.e_instr);
    chk({tag, " pc"},        pc,                v.e_pc);
    chk({tag, " misalign"},  {31'h0, misalign}, {31'h0, v.e_mis});
  endtask

  task automatic drive(input vec_t v);
    redirect_valid  = v.rv;
    redirect_target = v.rt;
    imem_ack        = v.ack;
    imem_rdata      = v.rdata;
    if_ready        = v.rdy;
  endtask

  initial begin
    vec_t z;
    // Sequential fetch 0,4,8 with ack one cycle after req and decode always ready.
    add(0, 0, 0, 0, 1,                      0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
    add(0, 0, 0, 0, 1,                      1, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
    add(0, 0, 1, 32'hA000_0000, 1,          1, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
    add(0, 0, 0, 0, 1,                      0, 32'h0, 1, 32'h0, 32'hA000_0000, 32'h4, 0);
    add(0, 0, 0, 0, 1,                      1, 32'h4, 0, 32'h0, 32'hA000_0000, 32'h4, 0);
    add(0, 0, 1, 32'hA000_0004, 1,          1, 32'h4, 0, 32'h0, 32'hA000_0000, 32'h4, 0);
    add(0, 0, 0, 0, 1,                      0, 32'h4, 1, 32'h4, 32'hA000_0004, 32'h8, 0);
    add(0, 0, 0, 0, 1,                      1, 32'h8, 0, 32'h4, 32'hA000_0004, 32'h8, 0);
    add(0, 0, 1, 32'hA000_0008, 0,          1, 32'h8, 0, 32'h4, 32'hA000_0004, 32'h8, 0);
    // Decode back-pressure for 5 cycles, then release.
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0,                    0, 32'h8, 1, 32'h8, 32'hA000_0008, 32'hC, 0);
    add(0, 0, 0, 0, 1,                      0, 32'h8, 1, 32'h8, 32'hA000_0008, 32'hC, 0);
    // Redirect to 0x100 while fetch of 0xC is pending; ack three cycles later is dropped.
    add(1, 32'h100, 0, 0, 0,                1, 32'hC, 0, 32'h8, 32'hA000_0008, 32'hC, 0);
    add(0, 0, 0, 0, 0,                      1, 32'hC, 0, 32'h8, 32'hA000_0008, 32'h100, 0);
    add(0, 0, 0, 0, 0,                      1, 32'hC, 0, 32'h8, 32'hA000_0008, 32'h100, 0);
    add(0, 0, 1, 32'hDEAD_BEEF, 0,          1, 32'hC, 0, 32'h8, 32'hA000_0008, 32'h100, 0);
    add(0, 0, 0, 0, 0,                      1, 32'h100, 0, 32'h8, 32'hA000_0008, 32'h100, 0);
    // Redirect to 0x40 in the ack cycle: data dropped, no gap in req.
    add(1, 32'h40, 1, 32'hBAD0_0000, 0,     1, 32'h100, 0, 32'h8, 32'hA000_0008, 32'h100, 0);
    add(0, 0, 1, 32'hA000_0040, 0,          1, 32'h40, 0, 32'h8, 32'hA000_0008, 32'h40, 0);
    // Misaligned redirect 0x203 in STALL, colliding with if_ready.
    add(1, 32'h203, 0, 0, 1,                0, 32'h40, 1, 32'h40, 32'hA000_0040, 32'h44, 0);
    add(0, 0, 0, 0, 0,                      1, 32'h200, 0, 32'h40, 32'hA000_0040, 32'h200, 1);
    add(0, 0, 1, 32'hA000_0200, 0,          1, 32'h200, 0, 32'h40, 32'hA000_0040, 32'h200, 0);
    // Redirect to the top word, fetch it, pc wraps to 0.
    add(1, 32'hFFFF_FFFC, 0, 0, 0,          0, 32'h200, 1, 32'h200, 32'hA000_0200, 32'h204, 0);
    add(0, 0, 1, 32'h1234_5678, 0,          1, 32'hFFFF_FFFC, 0, 32'h200, 32'hA000_0200, 32'hFFFF_FFFC, 0);
    add(0, 0, 0, 0, 1,                      0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 0);
    add(0, 0, 0, 0, 0,                      1, 32'h0, 0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 0);

    // Clock/reset block.
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset state", {30'h0, state_dbg}, 32'h0);

    foreach (vecs[i]) begin
      chk_outs($sformatf("vec%0d", i), vecs[i]);
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
    end

    // Reset asserted mid-request with an ack pending: everything clears at once.
    z = '{default: '0};
    drive(z);
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    #1 reset = 1'b1;
    #1;
    chk_outs("async reset", z);
    chk("async reset state", {30'h0, state_dbg}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk_outs("held reset", z);
    imem_ack = 1'b0;
    reset = 1'b0;
    chk("post-reset state", {30'h0, state_dbg}, 32'h0);

    // Misaligned redirect from IDLE: fetch proceeds from aligned target.
    redirect_valid = 1'b1; redirect_target = 32'h81;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0; redirect_target = 32'h0;
    chk("idle redir req",  {31'h0, imem_req}, 32'h1);
    chk("idle redir addr", imem_addr, 32'h80);
    chk("idle redir pc",   pc, 32'h80);
    chk("idle redir mis",  {31'h0, misalign}, 32'h1);
    chk("idle redir state", {30'h0, state_dbg}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("mis pulse end", {31'h0, misalign}, 32'h0);
    chk("req held", {31'h0, imem_req}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
